apb_slave_register_bank: RTL and testbench

APB completer access controller and register bank sitting directly downstream of the APB address mapping stage. It consumes the decoded `write_select`, `read_select` and `pslverr` from that stage and runs the APB setup/access handshake with a configurable number of wait states. It holds the payload and data-size registers and a saturating error-status counter, and drives `prdata`, `pready` and `pslverr` back to the requester.

---
 rtl/apb_slave_register_bank.sv | 116 +++++++++++
 tb/tb_apb_slave_register_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/apb_slave_register_bank.sv
// APB completer: setup/access handshake, payload/size registers and saturating error counter.
// Optional wait states are enabled by defining APB_WAIT_STATE_EN (otherwise pready rises in the first access cycle).
module apb_slave_register_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel_x,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [1:0]            write_select,
  input  logic [1:0]            read_select,
  input  logic                  pslverr_in,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] payload_lo,
  output logic [DATA_WIDTH-1:0] payload_hi,
  output logic [DATA_WIDTH-1:0] data_size,
  output logic                  payload_valid
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [7:0]            err_count;
  logic                  cnt_zero;
  logic                  done;
  logic [DATA_WIDTH-1:0] rd_val;

`ifdef APB_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [3:0] cnt;

  // Counter is reloaded on every setup, so an abort may leave it stale harmlessly.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      if (psel_x && !penable) cnt <= WAIT_LOAD;
    end else if (psel_x && penable && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign cnt_zero = (cnt == 4'd0);
`else
  logic unused_wait;
  assign unused_wait = ^WAIT_CYCLES;
  assign cnt_zero    = 1'b1;
`endif

  assign pready  = (state == ACCESS) && cnt_zero;
  assign pslverr = pready && pslverr_in;
  assign done    = pready && psel_x && penable;

  always_comb begin
    rd_val = '0;
    case (read_select)
      2'd0: rd_val = {{(DATA_WIDTH-8){1'b0}}, err_count};
      2'd1: rd_val = payload_lo;
      2'd2: rd_val = payload_hi;
      2'd3: rd_val = data_size;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= IDLE;
      prdata        <= '0;
      payload_lo    <= '0;
      payload_hi    <= '0;
      data_size     <= '0;
      err_count     <= '0;
      payload_valid <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (psel_x && !penable) begin
            state  <= ACCESS;
            prdata <= (!pwrite && !pslverr_in) ? rd_val : '0;
          end
        end
        ACCESS: begin
          if (!psel_x) begin
            state <= IDLE;
          end else if (done) begin
            state <= IDLE;
            if (pslverr_in) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (pwrite) begin
              case (write_select)
                2'd0: payload_lo <= pwdata;
                2'd1: begin
                  payload_hi    <= pwdata;
                  payload_valid <= 1'b1;
                end
                2'd2: data_size <= pwdata;
                default: ;
              endcase
            end else if (read_select == 2'd0) begin
              err_count <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_register_bank.sv
// Directed bench for apb_slave_register_bank; expected latency follows APB_WAIT_STATE_EN.
module tb_apb_slave_register_bank;

  localparam int WC = 2;
`ifdef APB_WAIT_STATE_EN
  localparam int EW = WC;
`else
  localparam int EW = 0;
`endif

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel_x, penable, pwrite, pslverr_in;
  logic [31:0] pwdata;
  logic [1:0]  write_select, read_select;
  logic [31:0] prdata, payload_lo, payload_hi, data_size;
  logic        pready, pslverr, payload_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        se;

  always #5 pclk = ~pclk;

  apb_slave_register_bank #(.DATA_WIDTH(32), .WAIT_CYCLES(WC)) dut (
    .pclk(pclk), .presetn(presetn), .psel_x(psel_x), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .write_select(write_select),
    .read_select(read_select), .pslverr_in(pslverr_in), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .payload_lo(payload_lo),
    .payload_hi(payload_hi), .data_size(data_size), .payload_valid(payload_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge with the bus idle.
  task automatic xfer(input logic wr, input logic [1:0] ws, input logic [1:0] rs,
                      input logic err, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic serr);
    psel_x = 1'b1; penable = 1'b0; pwrite = wr; write_select = ws;
    read_select = rs; pslverr_in = err; pwdata = wd;
    @(posedge pclk); #1 penable = 1'b1;
    for (int i = 0; i <= EW; i++) begin
      @(negedge pclk);
      chk((i == EW) ? "pready_done" : "pready_wait", {31'd0, pready}, {31'd0, (i == EW)});
    end
    rdata = prdata;
    serr  = pslverr;
    @(posedge pclk); #1;
    psel_x = 1'b0; penable = 1'b0; pwrite = 1'b0; pslverr_in = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; psel_x = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; write_select = 2'd3; read_select = 2'd0; pslverr_in = 1'b0;
    #2;
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_lo", payload_lo, 32'd0);
    chk("rst_hi", payload_hi, 32'd0);
    chk("rst_size", data_size, 32'd0);
    chk("rst_pv", {31'd0, payload_valid}, 32'd0);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    // Reset during the access phase of a write drops it.
    psel_x = 1'b1; penable = 1'b0; pwrite = 1'b1; write_select = 2'd0; pwdata = 32'hAAAA5555;
    @(posedge pclk); #1 penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, pready}, 32'd0);
    chk("midrst_prdata", prdata, 32'd0);
    chk("midrst_lo", payload_lo, 32'd0);
    @(negedge pclk); presetn = 1'b1; psel_x = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge pclk); #1;
    chk("midrst_lo_after", payload_lo, 32'd0);

    // Write then back-to-back read.
    xfer(1'b1, 2'd0, 2'd0, 1'b0, 32'hDEADBEEF, rd, se);
    chk("wr_lo_serr", {31'd0, se}, 32'd0);
    chk("wr_lo_reg", payload_lo, 32'hDEADBEEF);
    chk("wr_lo_pv", {31'd0, payload_valid}, 32'd0);
    xfer(1'b0, 2'd3, 2'd1, 1'b0, 32'd0, rd, se);
    chk("rd_lo_data", rd, 32'hDEADBEEF);
    chk("rd_lo_serr", {31'd0, se}, 32'd0);

    // payload_hi write pulses payload_valid for one cycle.
    xfer(1'b1, 2'd1, 2'd0, 1'b0, 32'h12345678, rd, se);
    chk("wr_hi_reg", payload_hi, 32'h12345678);
    chk("wr_hi_pv1", {31'd0, payload_valid}, 32'd1);
    @(posedge pclk); #1;
    chk("wr_hi_pv0", {31'd0, payload_valid}, 32'd0);

    xfer(1'b1, 2'd2, 2'd0, 1'b0, 32'h00000040, rd, se);
    xfer(1'b0, 2'd3, 2'd3, 1'b0, 32'd0, rd, se);
    chk("rd_size", rd, 32'h00000040);
    xfer(1'b0, 2'd3, 2'd2, 1'b0, 32'd0, rd, se);
    chk("rd_hi", rd, 32'h12345678);

    // write_select 3 is a silent no-op.
    xfer(1'b1, 2'd3, 2'd0, 1'b0, 32'hFFFFFFFF, rd, se);
    chk("ws3_serr", {31'd0, se}, 32'd0);
    chk("ws3_lo", payload_lo, 32'hDEADBEEF);
    chk("ws3_hi", payload_hi, 32'h12345678);
    chk("ws3_size", data_size, 32'h00000040);

    // Abort: psel drops during access.
    psel_x = 1'b1; penable = 1'b0; pwrite = 1'b1; write_select = 2'd0; pwdata = 32'h0BADF00D;
    @(posedge pclk); #1 psel_x = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_pready", {31'd0, pready}, 32'd0);
    chk("abort_lo", payload_lo, 32'hDEADBEEF);
    pwrite = 1'b0;

    // Error path.
    xfer(1'b1, 2'd0, 2'd0, 1'b1, 32'hBAD0BAD0, rd, se);
    chk("err1_serr", {31'd0, se}, 32'd1);
    xfer(1'b0, 2'd3, 2'd1, 1'b1, 32'd0, rd, se);
    chk("err2_serr", {31'd0, se}, 32'd1);
    chk("err2_prdata", rd, 32'd0);
    xfer(1'b1, 2'd1, 2'd0, 1'b1, 32'h0000BEEF, rd, se);
    chk("err3_serr", {31'd0, se}, 32'd1);
    chk("err3_pv", {31'd0, payload_valid}, 32'd0);
    chk("err_lo", payload_lo, 32'hDEADBEEF);
    chk("err_hi", payload_hi, 32'h12345678);
    xfer(1'b0, 2'd3, 2'd0, 1'b0, 32'd0, rd, se);
    chk("errstat_3", rd, 32'd3);
    xfer(1'b0, 2'd3, 2'd0, 1'b0, 32'd0, rd, se);
    chk("errstat_clr", rd, 32'd0);

    // Saturation at 255.
    for (int n = 0; n < 300; n++) xfer(1'b0, 2'd3, 2'd1, 1'b1, 32'd0, rd, se);
    xfer(1'b0, 2'd3, 2'd0, 1'b0, 32'd0, rd, se);
    chk("errstat_sat", rd, 32'd255);
    xfer(1'b0, 2'd3, 2'd0, 1'b0, 32'd0, rd, se);
    chk("errstat_sat_clr", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
